pipe_trace_monitor: RTL

PIPE_TRACE_MONITOR -- requirements
Module: pipe_trace_monitor

---
 rtl/pipe_trace_pkg.sv | 18 +
 rtl/pipe_trace_monitor_if.sv | 13 +
 rtl/trace_fifo.sv | 54 +++++
 rtl/pipe_trace_monitor.sv | 122 ++++++++++++
 4 files changed

// File: rtl/pipe_trace_pkg.sv
// Shared trace record definitions for the pipeline trace monitor.
// Records are packed {kind, addr, data}, with kind in the top bits.
package pipe_trace_pkg;

  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_STORE = 2'd1,
    KIND_LOAD  = 2'd2,
    KIND_ALU   = 2'd3
  } trace_kind_e;

  localparam int unsigned KIND_W = 2;

  function automatic int unsigned rec_width(input int unsigned data_w);
    return KIND_W + 2 * data_w;
  endfunction

endpackage

// File: rtl/pipe_trace_monitor_if.sv
// Trace output stream: first-word-fall-through valid/ready handshake.
interface pipe_trace_monitor_if #(
  parameter int unsigned DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_kind;
  logic [DATA_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (output out_valid, out_kind, out_addr, out_data, input out_ready);
  modport slave  (input out_valid, out_kind, out_addr, out_data, output out_ready);
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FWFT FIFO; a push into a full FIFO is accepted only alongside a pop.
module trace_fifo #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH is implicit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/pipe_trace_monitor.sv
// Captures MEM-stage store/load/ALU events into a trace FIFO, counts cycles,
// and freezes capture once the fetch stage sits on one instruction (halt).
module pipe_trace_monitor
  import pipe_trace_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HALT_REPEAT = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [DATA_W-1:0]         finst,
  input  logic [DATA_W-1:0]         mresult,
  input  logic [DATA_W-1:0]         mqb,
  input  logic [DATA_W-1:0]         mram_data,
  input  logic                      mwreg,
  input  logic                      mm2reg,
  input  logic                      mwmem,
  pipe_trace_monitor_if.master      trace,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [CNT_W-1:0]          drop_count,
  output logic [CNT_W-1:0]          cycle_count,
  output logic                      halted
);
  localparam int unsigned REC_W = rec_width(DATA_W);
  localparam int unsigned RPT_W = $clog2(HALT_REPEAT) + 1;
  localparam logic [RPT_W-1:0] RPT_LIMIT = RPT_W'(HALT_REPEAT - 1);

  trace_kind_e       rec_kind;
  logic [DATA_W-1:0] rec_addr;
  logic [DATA_W-1:0] rec_data;
  logic [REC_W-1:0]  rec;
  logic [REC_W-1:0]  head;
  logic              capture;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              drop;
  logic [DATA_W-1:0] prev_finst;
  logic [RPT_W-1:0]  repeat_cnt;

  assign capture = enable & ~halted;

  always_comb begin
    rec_kind = KIND_NONE;
    rec_addr = '0;
    rec_data = '0;
    if (mwmem) begin
      rec_kind = KIND_STORE;
      rec_addr = mresult;
      rec_data = mqb;
    end else if (mwreg && mm2reg) begin
      rec_kind = KIND_LOAD;
      rec_addr = mresult;
      rec_data = mram_data;
    end else if (mwreg) begin
      rec_kind = KIND_ALU;
      rec_data = mresult;
    end
  end

  assign rec  = {rec_kind, rec_addr, rec_data};
  assign push = capture & (rec_kind != KIND_NONE);
  // out_valid comes from the registered count, so out_ready never reaches it combinationally.
  assign pop  = trace.out_valid & trace.out_ready;
  assign drop = push & full & ~pop;

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   (rec),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign trace.out_valid = ~empty;
  assign trace.out_kind  = empty ? KIND_NONE : head[REC_W-1 -: KIND_W];
  assign trace.out_addr  = head[2*DATA_W-1 -: DATA_W];
  assign trace.out_data  = head[DATA_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow    <= 1'b0;
      drop_count  <= '0;
      cycle_count <= '0;
      halted      <= 1'b0;
      prev_finst  <= '0;
      repeat_cnt  <= '0;
    end else begin
      if (capture && cycle_count != '1) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
      end
      // Repeat count saturates at the limit; halted latches the cycle it is reached.
      if (enable) begin
        prev_finst <= finst;
        if (finst == prev_finst) begin
          if (repeat_cnt != RPT_LIMIT) repeat_cnt <= repeat_cnt + RPT_W'(1);
          if (repeat_cnt + RPT_W'(1) == RPT_LIMIT) halted <= 1'b1;
        end else begin
          repeat_cnt <= '0;
        end
      end else begin
        repeat_cnt <= '0;
      end
    end
  end
endmodule
